// File: rtl/axis_delay_pair.sv
// AXI-Stream pairing stage: outputs {x[n-D], x[n]} through one register slice.
// Define AXIS_DELAY_PAIR_TLAST_RESTART_EN to restart history after every tlast beat.
module axis_delay_pair #(
    parameter int WIDTH         = 32,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [$clog2(MAX_DELAY+1)-1:0] cfg_delay,
    input  logic                           cfg_delay_valid,
    input  logic [WIDTH-1:0]               s_axis_tdata,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [2*WIDTH-1:0]             m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           dbg_state_o,
    output logic [$clog2(MAX_DELAY+1)-1:0] dbg_delay_o
);
    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int PW = $clog2(MAX_DELAY);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    // Handshakes: a beat moves on an interface when its valid and ready are
    // both high at a rising clk edge; valid never depends on ready.
    state_t               state_q, state_d;
    logic [DW-1:0]        delay_q, delay_d;
    logic [DW-1:0]        fill_q, fill_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr;
    logic [WIDTH-1:0]     mem_q [MAX_DELAY];
    logic [WIDTH-1:0]     hist_word;
    logic [2*WIDTH-1:0]   tdata_q, tdata_d;
    logic                 tlast_q, tlast_d;
    logic                 tuser_q, tuser_d;
    logic                 tvalid_q, tvalid_d;
    logic                 accept;
    logic                 tlast_restart;
    logic [DW-1:0]        cfg_clamped;

    assign s_axis_tready = !tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    // D == MAX_DELAY truncates to 0, which reads the slot about to be overwritten.
    assign rd_ptr        = wr_ptr_q - delay_q[PW-1:0];
    assign hist_word     = (state_q == RUN) ? mem_q[rd_ptr] : {WIDTH{1'b0}};

`ifdef AXIS_DELAY_PAIR_TLAST_RESTART_EN
    assign tlast_restart = accept && s_axis_tlast;
`else
    assign tlast_restart = 1'b0;
`endif

    always_comb begin
        cfg_clamped = cfg_delay;
        if (cfg_delay > DW'(MAX_DELAY)) begin
            cfg_clamped = DW'(MAX_DELAY);
        end else if (cfg_delay == '0) begin
            cfg_clamped = DW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;

        if (accept) begin
            tvalid_d = 1'b1;
            tlast_d  = s_axis_tlast;
            tuser_d  = (state_q == RUN);
            tdata_d  = {hist_word, s_axis_tdata};
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (fill_q != delay_q) begin
                fill_d = fill_q + DW'(1);
            end
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            FILL:    if (fill_d == delay_q) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase

        // The beat accepted alongside a restart already used the old D and is not counted.
        if (cfg_delay_valid || tlast_restart) begin
            fill_d  = '0;
            state_d = FILL;
        end
        if (cfg_delay_valid) begin
            delay_d = cfg_clamped;
        end

        if (clear) begin
            state_d  = FILL;
            delay_d  = delay_q;
            fill_d   = '0;
            wr_ptr_d = '0;
            tdata_d  = tdata_q;
            tlast_d  = tlast_q;
            tuser_d  = tuser_q;
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FILL;
            delay_q  <= DW'(DEFAULT_DELAY);
            fill_q   <= '0;
            wr_ptr_q <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    // History RAM has no reset; entries are only shown once FILL has rewritten them.
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign dbg_state_o   = state_q;
    assign dbg_delay_o   = delay_q;

endmodule

// File: tb/tb_axis_delay_pair.sv
// Randomized bench for axis_delay_pair: a queue-based reference model predicts
// every output beat; directed phases cover restart, clamp, clear and reset.
module tb_axis_delay_pair;
    localparam int W    = 32;
    localparam int MAXD = 64;
    localparam int DEFD = 16;
    localparam int DW   = $clog2(MAXD + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            clear = 1'b0;
    logic [DW-1:0]   cfg_delay = '0;
    logic            cfg_delay_valid = 1'b0;
    logic [W-1:0]    s_axis_tdata = '0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [2*W-1:0]  m_axis_tdata;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            dbg_state_o;
    logic [DW-1:0]   dbg_delay_o;

    axis_delay_pair #(.WIDTH(W), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .cfg_delay(cfg_delay), .cfg_delay_valid(cfg_delay_valid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .dbg_state_o(dbg_state_o), .dbg_delay_o(dbg_delay_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard & model ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;              // 0 always, 1 toggle, 2 random, 3 stalled
    logic [2*W+1:0] exp_q[$];      // {tuser, tlast, upper, lower}
    logic [W-1:0]   hist[$];       // every sample accepted since the last clear/reset
    int             m_d = DEFD;    // model delay
    int             m_since = 0;   // beats accepted since the last restart

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > MAXD) return MAXD;
        if (v == 0) return 1;
        return v;
    endfunction

    task automatic model_beat(input logic [W-1:0] d, input logic l);
        logic [W-1:0] up;
        logic         usr;
        usr = (m_since >= m_d);
        up  = usr ? hist[hist.size() - m_d] : '0;
        exp_q.push_back({usr, l, up, d});
        hist.push_back(d);
        m_since++;
`ifdef AXIS_DELAY_PAIR_TLAST_RESTART_EN
        if (l) m_since = 0;
`endif
    endtask

    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                logic [2*W+1:0] e;
                e = exp_q.pop_front();
                check("m_axis_tdata", m_axis_tdata, e[2*W-1:0]);
                check("m_axis_tlast", m_axis_tlast, e[2*W]);
                check("m_axis_tuser", m_axis_tuser, e[2*W+1]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ~m_axis_tready;
                2: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [W-1:0] d, input logic l,
                             input logic with_cfg = 1'b0, input logic [DW-1:0] cfg = '0);
        int guard;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            guard++;
            if (guard > 100) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        if (guard <= 100) begin
            model_beat(d, l);
            if (with_cfg) begin
                cfg_delay       = cfg;
                cfg_delay_valid = 1'b1;
                m_d     = clamp(int'(cfg));
                m_since = 0;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid   = 1'b0;
        cfg_delay_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [DW-1:0] v);
        cfg_delay       = v;
        cfg_delay_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_delay_valid = 1'b0;
        m_d     = clamp(int'(v));
        m_since = 0;
    endtask

    task automatic stream(input int first, input int count);
        for (int i = 0; i < count; i++) send_beat(W'(first + i), 1'b0);
    endtask

    task automatic drain();
        int guard;
        rdy_mode = 0;
        guard = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tready", s_axis_tready, 1);
        check("rst_delay", dbg_delay_o, DEFD);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Samples 1..40 with the default delay of 16.
        stream(1, 40);
        drain();
        check("run_state", dbg_state_o, 1);

        // Shorter delay loaded mid-stream.
        load_cfg(DW'(4));
        check("cfg4", dbg_delay_o, 4);
        stream(21, 10);
        drain();

        // Backpressure on alternate cycles.
        load_cfg(DW'(3));
        rdy_mode = 1;
        stream(1, 10);
        drain();

        // Oversized and zero requests clamp.
        load_cfg(DW'(200));
        check("cfg_clamp_hi", dbg_delay_o, MAXD);
        rdy_mode = 2;
        stream(1, 70);
        drain();
        load_cfg(DW'(0));
        check("cfg_clamp_lo", dbg_delay_o, 1);
        stream(100, 5);
        drain();

        // Load colliding with an accepted beat.
        load_cfg(DW'(8));
        stream(1, 12);
        send_beat(W'(13), 1'b0, 1'b1, DW'(5));
        check("cfg_same_beat", dbg_delay_o, 5);
        stream(14, 10);
        drain();

        // Clear with an output in flight, a new beat offered and a load requested.
        load_cfg(DW'(8));
        stream(1, 10);
        clear           = 1'b1;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = 32'hDEAD_BEEF;
        cfg_delay       = DW'(3);
        cfg_delay_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; s_axis_tvalid = 1'b0; cfg_delay_valid = 1'b0;
        hist.delete();
        m_since = 0;
        check("clear_tvalid", m_axis_tvalid, 0);
        check("clear_keeps_d", dbg_delay_o, 8);
        check("clear_state", dbg_state_o, 0);
        stream(50, 12);
        drain();

        // Asynchronous reset mid-stream with an output held by backpressure.
        stream(70, 10);
        rdy_mode = 3;
        send_beat(W'(80), 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        check("mid_rst_tready", s_axis_tready, 1);
        check("mid_rst_delay", dbg_delay_o, DEFD);
        exp_q.delete();
        hist.delete();
        m_since = 0;
        m_d = DEFD;
        rdy_mode = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        stream(200, 20);
        drain();

        // Two packets of five with D=2.
        load_cfg(DW'(2));
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 5; i++) send_beat(W'(10 * p + i + 1), i == 4);
        drain();

        // Random traffic: data, tlast, gaps, loads and backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat($urandom, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 24) == 0, DW'($urandom_range(0, 127)));
        end
        drain();

        check("leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
